// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO and its backing RAM.
//   DEF_MEM_WIDTH / DEF_MEM_DEPTH : default word width and entry count
//   addr_w()                      : pointer width for a given depth
// Build option: define FIFO_ERR_EN to generate the sticky overflow /
// underflow error logic inside fifo_sync.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_MEM_WIDTH = 10;
    localparam int DEF_MEM_DEPTH = 8;

    // Pointer width; depth is a power of two >= 2, so this is exact.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dual_port_ram.sv
// ---------------------------------------------------------------------------
// dual_port_ram
// Simple dual-port RAM with one synchronous write port and one registered
// read port, each with its own address and enable.
//   clk      : clock, all activity on the rising edge
//   reset_L  : async active-low reset, clears the read register only
//   wr_en    : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read enable, loads rd_data from mem[rd_addr]
//   rd_addr  : read address
//   rd_data  : registered read data, holds when rd_en is low
// Storage contents are not reset.
// ---------------------------------------------------------------------------
module dual_port_ram
    import fifo_pkg::*;
#(
    parameter int MEM_WIDTH = DEF_MEM_WIDTH,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    localparam int ADDR_W   = addr_w(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [MEM_WIDTH-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [MEM_WIDTH-1:0] rd_data
);

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read samples the array before this edge's write lands, so a
    // same-address read/write returns the old word.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// ---------------------------------------------------------------------------
// fifo_sync
// Single-clock FIFO around dual_port_ram: pointers, occupancy count,
// full/empty/watermark flags and a registered read path with valid strobe.
//   clk            : clock
//   reset_L        : async active-low reset, discards all contents
//   push           : write request, Fifo_Data_in sampled when accepted
//   Fifo_Data_in   : write data
//   pop            : read request
//   Fifo_Data_out  : registered read data, holds when no pop is accepted
//   data_valid     : Fifo_Data_out carries a word popped at the last edge
//   full / empty   : count == MEM_DEPTH / count == 0
//   almost_full    : count >= ALMOST_FULL_TH
//   almost_empty   : count <= ALMOST_EMPTY_TH
//   fifo_count     : occupancy 0..MEM_DEPTH
//   overflow       : sticky rejected push   (FIFO_ERR_EN only, else 0)
//   underflow      : sticky rejected pop    (FIFO_ERR_EN only, else 0)
//
// Handshake: there is no ready; empty/full act as the inverse readies.
// A pop is accepted when the FIFO is not empty. A push is accepted when
// not full, or when full and a pop is accepted at the same edge. On an
// empty FIFO push+pop accepts only the push (no fall-through).
// ---------------------------------------------------------------------------
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int MEM_WIDTH       = DEF_MEM_WIDTH,
    parameter int MEM_DEPTH       = DEF_MEM_DEPTH,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2,
    localparam int ADDR_W         = addr_w(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 push,
    input  logic [MEM_WIDTH-1:0] Fifo_Data_in,
    input  logic                 pop,
    output logic [MEM_WIDTH-1:0] Fifo_Data_out,
    output logic                 data_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_W:0]      fifo_count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(ALMOST_EMPTY_TH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              valid_q;
    logic              pop_ok;
    logic              push_ok;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Flags decode the registered count only.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign fifo_count   = count_q;
    assign data_valid   = valid_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= pop_ok;
            // Pointers are exactly ADDR_W bits, so they wrap on their own.
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    dual_port_ram #(
        .MEM_WIDTH (MEM_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset_L (reset_L),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (Fifo_Data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (Fifo_Data_out)
    );

`ifdef FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
            if (pop && !pop_ok) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: doc/fifo_sync.md
# fifo_sync

Synchronous single-clock FIFO built on a parametrised dual-port RAM. It adds the read/write pointers, occupancy counting, full/empty and watermark flags, and a registered read-data path with a valid strobe. Producers push on one side and consumers pop on the other. It replaces hand-wired pointer logic around the bare memory in the datapath FIFOs, and feeds the flow-control logic through its almost-full and almost-empty outputs.

## Interface
- MEM_WIDTH, 10, data word width in bits (≥1)
- MEM_DEPTH, 8, number of entries; power of two, ≥2
- ALMOST_FULL_TH, 6, almost_full asserted when count ≥ this value (1..MEM_DEPTH)
- ALMOST_EMPTY_TH, 2, almost_empty asserted when count ≤ this value (0..MEM_DEPTH-1)
- clk  input  1  single clock, all state on the rising edge
- reset_L  input  1  asynchronous, active-low reset
- push  input  1  write request
- Fifo_Data_in  input  MEM_WIDTH  write data, sampled when the push is accepted
- pop  input  1  read request
- Fifo_Data_out  output  MEM_WIDTH  registered read data
- data_valid  output  1  Fifo_Data_out holds a freshly popped word this cycle
- full  output  1  count == MEM_DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ ALMOST_FULL_TH
- almost_empty  output  1  count ≤ ALMOST_EMPTY_TH
- fifo_count  output  ADDR_W+1  occupancy, 0..MEM_DEPTH
- overflow  output  1  sticky: a push was rejected
- underflow  output  1  sticky: a pop was rejected

## Operation
- ADDR_W = $clog2(MEM_DEPTH). The write pointer and read pointer are each ADDR_W bits and wrap naturally from MEM_DEPTH-1 to 0.
- pop_ok = pop && !empty.
- push_ok = push && (!full || pop_ok). A push into a full FIFO is accepted if a pop is accepted in the same cycle.
- When empty, push && pop accepts only the push. The pop is rejected, and there is no fall-through.
- push_ok writes mem[wr_ptr] and increments wr_ptr.
- pop_ok loads Fifo_Data_out from mem[rd_ptr] and increments rd_ptr.
- On a same-edge read and write to the same entry (only possible when full), the read returns the old contents.
- Count update:
  - +1 when only push_ok
  - −1 when only pop_ok
  - unchanged when both or neither
- The flags are combinational decodes of the registered count, so they are valid at the same edge the count updates.
- Fifo_Data_out holds its last value when no pop is accepted.
- Reset values:
  - pointers = 0, count = 0
  - Fifo_Data_out = 0, data_valid = 0
  - empty = 1, full = 0
  - almost_empty = 1; almost_full = 0
  - overflow = 0, underflow = 0
  - RAM contents are not reset.
- An assertion of reset mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Read latency is 1 cycle. A pop accepted at edge N gives data on Fifo_Data_out and data_valid = 1 after edge N, and data_valid clears after edge N+1 unless another pop is accepted.
- Write-to-read latency is 1 cycle. A word pushed at edge N can be popped at edge N+1, since empty deasserts after edge N.
- Sustained throughput is one push and one pop per cycle, including while full.
- Flags and fifo_count change only on clock edges or on reset.

## Configuration
- FIFO_ERR_EN defined:
  - overflow sets on push && !push_ok.
  - underflow sets on pop && !pop_ok.
  - Both flags are sticky until reset_L.
- FIFO_ERR_EN undefined:
  - overflow and underflow are tied to 0 and no error logic is generated.
  - The port list is unchanged.

## Structure
- Shared package fifo_pkg holds:
  - the ADDR_W derivation function
  - the default MEM_WIDTH and MEM_DEPTH constants
- Sub-module dual_port_ram (MEM_WIDTH, MEM_DEPTH) provides:
  - a synchronous write port and a registered read port
  - independent read and write addresses and enables
- fifo_sync instantiates dual_port_ram once and contains the pointers, count, flags and error logic.

## Test plan
- Reset, then 8 pushes of 0x001..0x008 with no pops → full = 1 after the 8th edge, almost_full = 1 from count 6, fifo_count = 8; a 9th push is rejected and, with FIFO_ERR_EN, overflow = 1.
- From full, 8 pops → Fifo_Data_out shows 0x001..0x008 in order, each with data_valid = 1 one cycle after its pop; then empty = 1 and almost_empty = 1 from count 2.
- Pop while empty → data_valid stays 0, Fifo_Data_out is unchanged, count stays 0, and underflow = 1 (with FIFO_ERR_EN only).
- Full FIFO with simultaneous push 0x3FF and pop → the oldest word is output, count stays 8, and 0x3FF is read out last after 8 further pops.
- Continuous push and pop for 20 cycles from count 3 → the pointers wrap at least twice, count stays 3, and data comes out in order with no loss.
- Assert reset_L low mid-stream between edges → all outputs return immediately to their reset values, and the next push/pop sequence behaves as if from a fresh start.
